// File: rtl/ysyx_22041211_ifu_if.sv
// AXI4-Lite-style read channel (AR + R) between the fetch unit and instruction memory.
// The fetch unit is the master; the memory side is the slave.
interface ysyx_22041211_ifu_if #(
  parameter int ADDR_LEN = 32,
  parameter int INST_LEN = 32
) ();
  logic [ADDR_LEN-1:0] araddr;
  logic                arvalid;
  logic                arready;
  logic [INST_LEN-1:0] rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: one single-beat read per pc, result handed to decode over valid/ready,
// and pc_wen pulses only once decode has accepted the instruction.
module ysyx_22041211_ifu #(
  parameter int ADDR_LEN = 32,
  parameter int INST_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] pc,
  output logic                pc_wen,
  input  logic                flush,
  ysyx_22041211_ifu_if.master bus,
  output logic [INST_LEN-1:0] inst,
  output logic [ADDR_LEN-1:0] inst_pc,
  output logic [1:0]          inst_fault,
  output logic                inst_valid,
  input  logic                inst_ready
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_HOLD} state_e;

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_BUS   = 2'b01;
  localparam logic [1:0] FAULT_ALIGN = 2'b10;

  state_e              state_q, state_d;
  logic                kill_q, kill_d;
  logic                first_q, first_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic [1:0]          fault_q, fault_d;

  logic [ADDR_LEN-1:0] cur_addr;
  logic                misaligned;

  // The first AR cycle reads pc live, so a pc_wen load at the previous edge is already visible;
  // from then on the latched copy keeps araddr stable until arready.
  assign cur_addr   = first_q ? pc : addr_q;
  assign misaligned = |cur_addr[1:0];

  always_comb begin
    // NOTE: every _d starts from a hold/default value so no branch of the case can infer a latch.
    state_d = state_q;
    kill_d  = kill_q;
    first_d = 1'b0;
    addr_d  = cur_addr;
    inst_d  = inst_q;
    fault_d = fault_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_AR;
        first_d = 1'b1;
      end

      S_AR: begin
        if (misaligned) begin
          // No bus request is made; a redirect simply resamples pc.
          if (flush) begin
            first_d = 1'b1;
          end else begin
            state_d = S_HOLD;
            inst_d  = '0;
            fault_d = FAULT_ALIGN;
          end
        end else begin
          if (flush) kill_d = 1'b1;
          if (bus.arready) state_d = S_R;
        end
      end

      S_R: begin
        if (bus.rvalid) begin
          if (kill_q || flush) begin
            kill_d  = 1'b0;
            state_d = S_AR;
            first_d = 1'b1;
          end else begin
            inst_d  = bus.rdata;
            fault_d = (bus.rresp != 2'b00) ? FAULT_BUS : FAULT_NONE;
            state_d = S_HOLD;
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (flush || inst_ready) begin
          state_d = S_AR;
          first_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
      first_q <= 1'b0;
      addr_q  <= '0;
      inst_q  <= '0;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      first_q <= first_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  assign bus.araddr  = cur_addr;
  assign bus.arvalid = (state_q == S_AR) && !misaligned;
  assign bus.rready  = (state_q == S_R);

  assign inst_valid = (state_q == S_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = addr_q;
  assign inst_fault = fault_q;
  assign pc_wen     = inst_valid && inst_ready && !flush;

endmodule
